fp_add_responder: RTL and testbench
===================================

FP_ADD_RESPONDER -- requirements
Module: fp_add_responder

Interface
REQ-001 SHALL have parameters: EXP_LEN, default 8, exponent width; MANTISSA_LEN, default 23, stored mantissa width; W = EXP_LEN+MANTISSA_LEN+1 is the word width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- add_a  in  W  operand A
- add_b  in  W  operand B
- add_start  in  1  request strobe
- add_sum  out  W  result A+B
- add_ready  out  1  result-valid strobe
- busy  out  1  operation in progress
REQ-003 SHALL serve as the responder of the add_a/add_b/add_start -> add_sum/add_ready handshake driven by the angle-normalization and other FP initiators.

Function
REQ-004 SHALL be a multicycle FSM with states IDLE, ALIGN, ADD, NORM, PACK.
REQ-005 In IDLE, add_start=1 at a rising edge SHALL capture add_a and add_b and move to ALIGN; add_start=0 SHALL remain in IDLE.
REQ-006 Transitions SHALL be unconditional: ALIGN->ADD->NORM->PACK->IDLE.
REQ-007 busy SHALL be 1 in every state except IDLE.
REQ-008 add_start while busy=1 SHALL be ignored, with no capture, no queuing and no effect on the running operation.
REQ-009 add_sum and add_ready SHALL be registered and updated on the edge leaving PACK.
- add_ready is therefore high for exactly one cycle, beginning 4 cycles after the edge that sampled add_start.
REQ-010 add_sum SHALL hold its value until the next result is produced.
- add_ready SHALL be 0 in all other cycles.
REQ-011 add_start may be re-asserted in the cycle in which add_ready=1; it SHALL be accepted, because the FSM is already in IDLE.
REQ-012 Zero and denormal inputs: an operand with exponent 0 SHALL be treated as +/-0, i.e. flush-to-zero.
REQ-013 Special values: if either operand is NaN, or the operands are infinities of opposite sign, the result SHALL be 0x7FC00000 (canonical quiet NaN, scaled to the parameters).
- Otherwise, if either operand is infinite, the result SHALL be that infinity.
REQ-014 ALIGN SHALL perform the following steps:
- Form each significand as {hidden 1, mantissa, 3'b000}; the hidden bit is 0 for a zero operand.
- Swap the operands so the larger magnitude is first.
- Shift the smaller right by the exponent difference d.
- OR all bits shifted out into the LSB (sticky).
- If d > MANTISSA_LEN+3, the smaller significand SHALL become 0 with sticky equal to (smaller != 0).
REQ-015 ADD SHALL add the significands if the signs are equal and subtract smaller from larger otherwise, with 1 carry bit of headroom.
- The result sign SHALL be the larger operand's sign.
REQ-016 NORM SHALL normalize in a single cycle using a leading-zero count:
- On carry, shift right by 1 and add 1 to the exponent.
- Otherwise, shift left by the leading-zero count and subtract it from the exponent.
REQ-017 PACK SHALL discard the 3 low bits (truncation, round toward zero) and pack the result.
REQ-018 An exact zero result SHALL be +0 (0x00000000).
REQ-019 Overflow (exponent >= 2^EXP_LEN-1) SHALL give signed infinity.
REQ-020 Underflow (exponent <= 0) SHALL give +0.
REQ-021 The exponent arithmetic SHALL use EXP_LEN+2 bit signed intermediates so that no wrap-around occurs.

Reset
REQ-022 While reset=0, the FSM SHALL go to IDLE asynchronously and the outputs SHALL be add_sum=0, add_ready=0, busy=0.
REQ-023 Reset asserted mid-operation SHALL abort the operation: no add_ready pulse follows, and add_sum stays 0.
REQ-024 The first add_start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-025 Pulse add_start with 0x3F800000 + 0x40000000 -> add_sum=0x40400000, add_ready high exactly 4 cycles after start, 1 cycle wide, busy=1 for those 4 cycles.
REQ-026 0x3FC00000 + 0xBE800000 -> 0x3FA00000; 0x40400000 + 0xC0400000 -> 0x00000000.
REQ-027 0x4B800000 + 0x3F800000 -> 0x4B800000 (truncation); 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 (overflow).
REQ-028 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x7F800000 + 0x3F800000 -> 0x7F800000; 0x00000001 + 0x3F800000 -> 0x3F800000 (flush-to-zero).
REQ-029 Start 1.0+2.0, re-pulse add_start with other operands 2 cycles later -> single result 0x40400000; then a back-to-back start in the add_ready cycle is accepted and its ready follows 4 cycles later.
REQ-030 Start an operation, assert reset=0 at cycle 2 -> outputs 0 immediately, no add_ready; after release, a new 1.0+1.0 -> 0x40000000.

Source files
------------

// File: rtl/fp_add_responder.sv
// Multicycle floating-point adder answering the add_a/add_b/add_start handshake.
// IDLE: wait for start | ALIGN: swap+shift | ADD: add/sub | NORM: lzc shift | PACK: round/pack
module fp_add_responder #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  localparam int W           = EXP_LEN + MANTISSA_LEN + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] add_a,
  input  logic [W-1:0] add_b,
  input  logic         add_start,
  output logic [W-1:0] add_sum,
  output logic         add_ready,
  output logic         busy
);

  localparam int SW  = MANTISSA_LEN + 4;
  localparam int EW  = EXP_LEN + 2;
  localparam int LZW = $clog2(SW + 1);

  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((2 ** EXP_LEN) - 1);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK} state_t;

  state_t state_q, state_d;

  logic [W-1:0]           a_q, b_q;
  logic [SW-1:0]          big_q, small_q;
  logic signed [EW-1:0]   exp_q;
  logic                   sign_q, sub_q;
  logic [SW:0]            sum_q;
  logic [SW-1:0]          norm_sig_q;
  logic signed [EW-1:0]   norm_exp_q;
  logic [W-1:0]           add_sum_q;
  logic                   add_ready_q;

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (v[i]) n = LZW'(SW - 1 - i);
    end
    return n;
  endfunction

  // Operand decode; exponent 0 is flushed to a signed zero.
  logic                    sign_a, sign_b, zero_a, zero_b;
  logic [EXP_LEN-1:0]      exp_a, exp_b;
  logic [MANTISSA_LEN-1:0] man_a, man_b, man_a_eff, man_b_eff;
  logic                    nan_a, nan_b, inf_a, inf_b;

  assign sign_a    = a_q[W-1];
  assign sign_b    = b_q[W-1];
  assign exp_a     = a_q[W-2:MANTISSA_LEN];
  assign exp_b     = b_q[W-2:MANTISSA_LEN];
  assign man_a     = a_q[MANTISSA_LEN-1:0];
  assign man_b     = b_q[MANTISSA_LEN-1:0];
  assign zero_a    = (exp_a == '0);
  assign zero_b    = (exp_b == '0);
  assign man_a_eff = zero_a ? '0 : man_a;
  assign man_b_eff = zero_b ? '0 : man_b;
  assign nan_a     = (exp_a == '1) && (man_a != '0);
  assign nan_b     = (exp_b == '1) && (man_b != '0);
  assign inf_a     = (exp_a == '1) && (man_a == '0);
  assign inf_b     = (exp_b == '1) && (man_b == '0);

  logic [SW-1:0]      sig_a, sig_b, sig_big, sig_small, small_sh, small_al, shift_mask;
  logic [EXP_LEN-1:0] exp_big, exp_small, diff;
  logic               sign_big, a_ge_b, sticky;

  assign sig_a  = {~zero_a, man_a_eff, 3'b000};
  assign sig_b  = {~zero_b, man_b_eff, 3'b000};
  assign a_ge_b = {exp_a, man_a_eff} >= {exp_b, man_b_eff};

  always_comb begin
    if (a_ge_b) begin
      sig_big   = sig_a;
      sig_small = sig_b;
      exp_big   = exp_a;
      exp_small = exp_b;
      sign_big  = sign_a;
    end else begin
      sig_big   = sig_b;
      sig_small = sig_a;
      exp_big   = exp_b;
      exp_small = exp_a;
      sign_big  = sign_b;
    end
  end

  assign diff = exp_big - exp_small;

  always_comb begin
    small_sh   = '0;
    shift_mask = '0;
    sticky     = 1'b0;
    if (int'(diff) > MANTISSA_LEN + 3) begin
      sticky = |sig_small;
    end else begin
      small_sh   = sig_small >> diff;
      shift_mask = ~({SW{1'b1}} << diff);
      sticky     = |(sig_small & shift_mask);
    end
    small_al = {small_sh[SW-1:1], small_sh[0] | sticky};
  end

  logic [SW:0] sum_d;
  assign sum_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                       : ({1'b0, big_q} + {1'b0, small_q});

  logic [LZW-1:0]       lz;
  logic [SW-1:0]        norm_sig_d;
  logic signed [EW-1:0] norm_exp_d;

  assign lz = lzc(sum_q[SW-1:0]);

  always_comb begin
    if (sum_q[SW]) begin
      norm_sig_d = sum_q[SW:1];
      norm_exp_d = exp_q + EXP_ONE;
    end else begin
      norm_sig_d = sum_q[SW-1:0] << lz;
      norm_exp_d = exp_q - $signed(EW'(lz));
    end
  end

  // Specials come straight from the captured operands, which stay frozen while busy.
  logic [W-1:0] result_d;
  always_comb begin
    result_d = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      result_d = QNAN;
    end else if (inf_a) begin
      result_d = a_q;
    end else if (inf_b) begin
      result_d = b_q;
    end else if (!norm_sig_q[SW-1]) begin
      result_d = '0;
    end else if (norm_exp_q >= EXP_MAX) begin
      result_d = {sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
    end else if (norm_exp_q <= EXP_ZERO) begin
      result_d = '0;
    end else begin
      result_d = {sign_q, norm_exp_q[EXP_LEN-1:0], norm_sig_q[SW-2:3]};
    end
  end

  logic unused_guard_bits;
  assign unused_guard_bits = ^norm_sig_q[2:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (add_start) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q         <= '0;
      b_q         <= '0;
      big_q       <= '0;
      small_q     <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      sum_q       <= '0;
      norm_sig_q  <= '0;
      norm_exp_q  <= '0;
      add_sum_q   <= '0;
      add_ready_q <= 1'b0;
    end else begin
      add_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (add_start) begin
            a_q <= add_a;
            b_q <= add_b;
          end
        end
        ALIGN: begin
          big_q   <= sig_big;
          small_q <= small_al;
          exp_q   <= $signed({2'b00, exp_big});
          sign_q  <= sign_big;
          sub_q   <= sign_a ^ sign_b;
        end
        ADD: sum_q <= sum_d;
        NORM: begin
          norm_sig_q <= norm_sig_d;
          norm_exp_q <= norm_exp_d;
        end
        PACK: begin
          add_sum_q   <= result_d;
          add_ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign add_sum   = add_sum_q;
  assign add_ready = add_ready_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_responder.sv
// Directed and randomized checks of fp_add_responder against an exact-arithmetic reference.
module tb_fp_add_responder;

  logic        clk;
  logic        reset;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_start, add_ready, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  fp_add_responder dut (
    .clk       (clk),
    .reset     (reset),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_start (add_start),
    .add_sum   (add_sum),
    .add_ready (add_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact sum on wide integers, then truncate toward zero to 24 significant bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]   ea, eb;
    logic [22:0]  ma, mb;
    logic         sa, sb, s;
    logic [299:0] va, vb, mag;
    int           emin, p, e;
    sa = a[31]; ea = a[30:23]; ma = a[22:0];
    sb = b[31]; eb = b[30:23]; mb = b[22:0];
    if ((ea == 8'hFF && ma != 0) || (eb == 8'hFF && mb != 0) ||
        (ea == 8'hFF && eb == 8'hFF && sa != sb))
      return 32'h7FC00000;
    if (ea == 8'hFF) return a;
    if (eb == 8'hFF) return b;
    va = '0; vb = '0;
    if (ea != 0) va[23:0] = {1'b1, ma};
    if (eb != 0) vb[23:0] = {1'b1, mb};
    emin = (ea < eb) ? int'(ea) : int'(eb);
    va = va << (int'(ea) - emin);
    vb = vb << (int'(eb) - emin);
    if (sa == sb) begin mag = va + vb; s = sa; end
    else if (va >= vb) begin mag = va - vb; s = sa; end
    else begin mag = vb - va; s = sb; end
    if (mag == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = emin + p - 23;
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    if (p >= 23) mag = mag >> (p - 23);
    else mag = mag << (23 - p);
    return {s, 8'(e), mag[22:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; drives one request and checks the whole response window.
  task automatic do_add(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input string tag);
    add_a = a; add_b = b; add_start = 1'b1;
    @(negedge clk);
    add_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, " busy"}, {30'b0, busy, add_ready}, 32'h2);
      @(negedge clk);
    end
    chk({tag, " ready"}, {30'b0, busy, add_ready}, 32'h1);
    chk({tag, " sum"}, add_sum, expv);
    @(negedge clk);
    chk({tag, " ready_low"}, {31'b0, add_ready}, 32'h0);
    chk({tag, " hold"}, add_sum, expv);
  endtask

  initial begin
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        sa, sb;
    logic [31:0] ra, rb;
    int          r, t;

    reset = 1'b0; add_start = 1'b0; add_a = '0; add_b = '0;
    #12;
    chk("reset sum", add_sum, 32'h0);
    chk("reset ready", {31'b0, add_ready}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    do_add(32'h3F800000, 32'h40000000, 32'h40400000, "one_plus_two");
    do_add(32'h3FC00000, 32'hBE800000, 32'h3FA00000, "sub_1p25");
    do_add(32'h40400000, 32'hC0400000, 32'h00000000, "cancel");
    do_add(32'h4B800000, 32'h3F800000, 32'h4B800000, "truncate");
    do_add(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow");
    do_add(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
    do_add(32'h7F800000, 32'h3F800000, 32'h7F800000, "inf_plus_one");
    do_add(32'h00000001, 32'h3F800000, 32'h3F800000, "ftz");
    do_add(32'h00800000, 32'h80800001, 32'h00000000, "underflow");
    do_add(32'h7FC12345, 32'h3F800000, 32'h7FC00000, "nan_in");

    add_a = 32'h3F800000; add_b = 32'h40000000; add_start = 1'b1;
    @(negedge clk);
    add_start = 1'b0;
    @(negedge clk);
    add_a = 32'h40A00000; add_b = 32'h40A00000; add_start = 1'b1;
    @(negedge clk);
    add_start = 1'b0;
    chk("ignored busy", {30'b0, busy, add_ready}, 32'h2);
    @(negedge clk);
    chk("ignored pack", {30'b0, busy, add_ready}, 32'h2);
    @(negedge clk);
    chk("ignored ready", {30'b0, busy, add_ready}, 32'h1);
    chk("ignored sum", add_sum, 32'h40400000);
    add_a = 32'h3FC00000; add_b = 32'hBE800000; add_start = 1'b1;
    @(negedge clk);
    add_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("b2b busy", {30'b0, busy, add_ready}, 32'h2);
      @(negedge clk);
    end
    chk("b2b ready", {30'b0, busy, add_ready}, 32'h1);
    chk("b2b sum", add_sum, 32'h3FA00000);
    @(negedge clk);
    chk("b2b ready_low", {31'b0, add_ready}, 32'h0);

    add_a = 32'h3F800000; add_b = 32'h40000000; add_start = 1'b1;
    @(negedge clk);
    add_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort sum", add_sum, 32'h0);
    chk("abort outs", {30'b0, busy, add_ready}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort held", {30'b0, busy, add_ready}, 32'h0);
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort no_ready", {30'b0, busy, add_ready}, 32'h0);
      chk("abort sum_zero", add_sum, 32'h0);
    end
    do_add(32'h3F800000, 32'h3F800000, 32'h40000000, "after_abort");

    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) ea = 8'h00;
      else if (r == 1) ea = 8'hFF;
      else if (r == 2) ea = 8'($urandom_range(250, 254));
      else if (r == 3) ea = 8'($urandom_range(1, 4));
      else ea = 8'($urandom_range(1, 254));
      r = int'($urandom_range(0, 7));
      if (r < 5) begin
        t = int'(ea) + int'($urandom_range(0, 60)) - 30;
        if (t < 1) t = 1;
        if (t > 254) t = 254;
        eb = 8'(t);
      end else if (r == 5) begin
        eb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      end else begin
        eb = 8'($urandom_range(0, 255));
      end
      ma = 23'($urandom);
      mb = 23'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        mb = ma;
        if ($urandom_range(0, 1) == 0) eb = ea;
      end
      if (ea == 8'hFF && $urandom_range(0, 1) == 0) ma = '0;
      if (eb == 8'hFF && $urandom_range(0, 1) == 0) mb = '0;
      sa = 1'($urandom);
      sb = 1'($urandom);
      ra = {sa, ea, ma};
      rb = {sb, eb, mb};
      do_add(ra, rb, ref_add(ra, rb), $sformatf("rand%0d %h+%h", it, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
